// File: rtl/decenc_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : decenc_pipe_if
// Purpose  : Handshake bundle for decenc_pipe. One valid/ready input channel
//            carrying mode + data, one valid/ready output channel carrying the
//            result, plus the error flag and transfer counter.
// Modports : slave  - the pipe itself (consumes input, produces output)
//            master - the environment driving the pipe
// Revision : 1.0 - initial release
// ============================================================================
interface decenc_pipe_if #(
  parameter int SEL_W  = 5,
  parameter int DATA_W = 2**SEL_W,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;
  logic [CNT_W-1:0]  txn_count;

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err, txn_count
  );

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err, txn_count
  );
endinterface
`default_nettype wire

// File: rtl/decenc_pipe.sv
`default_nettype none
// ============================================================================
// Module   : decenc_pipe
// Purpose  : One-stage registered decoder/encoder with valid/ready flow
//            control. Mode 0 decodes an index into a one-hot bus, mode 1
//            encodes a bus into the index of its lowest set bit. Completed
//            output transfers are counted with a saturating counter.
// Ports    : clk      - single clock, rising edge
//            rst      - synchronous active-high reset
//            pipe_io  - decenc_pipe_if.slave (in_valid/in_ready/in_mode/
//                       in_data, out_valid/out_ready/out_data, out_err,
//                       txn_count)
// Config   : DECENC_ERR_EN - when defined, out_err flags an encode of an
//            all-zero bus; otherwise out_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module decenc_pipe #(
  parameter int SEL_W  = 5,
  parameter int DATA_W = 2**SEL_W,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  decenc_pipe_if.slave pipe_io
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_xfer;
  logic              out_xfer;
  logic [SEL_W-1:0]  enc_idx;
  logic [DATA_W-1:0] dec_onehot;

  // Handshake: the register can take new data when empty or when its
  // current content leaves in the same cycle.
  assign pipe_io.out_valid = (state_q == ST_FULL);
  assign pipe_io.in_ready  = (state_q == ST_EMPTY) || pipe_io.out_ready;
  assign in_xfer           = pipe_io.in_valid && pipe_io.in_ready;
  assign out_xfer          = pipe_io.out_valid && pipe_io.out_ready;

  // Decode uses only the low SEL_W bits of the input.
  assign dec_onehot = DATA_W'(1) << pipe_io.in_data[SEL_W-1:0];

  // Scan from MSB down so the last hit wins, giving LSB priority.
  // An all-zero bus leaves the index at zero.
  always_comb begin
    enc_idx = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (pipe_io.in_data[i]) begin
        enc_idx = SEL_W'(i);
      end
    end
  end

  // Control FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (in_xfer) state_d = ST_FULL;
      ST_FULL:  if (out_xfer && !in_xfer) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Result register only loads on an input transfer; it holds otherwise.
  always_comb begin
    data_d = data_q;
    if (in_xfer) begin
      data_d = pipe_io.in_mode ? DATA_W'(enc_idx) : dec_onehot;
    end
  end

  // Saturating count of completed output transfers.
  always_comb begin
    cnt_d = cnt_q;
    if (out_xfer && (cnt_q != C_CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pipe_io.out_data  = data_q;
  assign pipe_io.txn_count = cnt_q;

`ifdef DECENC_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (in_xfer) begin
      err_d = pipe_io.in_mode && (pipe_io.in_data == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign pipe_io.out_err = err_q;
`else
  assign pipe_io.out_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decenc_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_decenc_pipe
// Purpose  : Self-checking bench for decenc_pipe. Directed vector table,
//            hand-written handshake/reset sequences, randomized traffic
//            against a behavioural model, and counter saturation on a
//            second instance with a 4-bit counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decenc_pipe;

`ifdef DECENC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decenc_pipe_if #(.SEL_W(5), .DATA_W(32), .CNT_W(16)) bus  ();
  decenc_pipe_if #(.SEL_W(5), .DATA_W(32), .CNT_W(4))  bus2 ();

  decenc_pipe #(.SEL_W(5), .DATA_W(32), .CNT_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .pipe_io (bus.slave)
  );

  decenc_pipe #(.SEL_W(5), .DATA_W(32), .CNT_W(4)) dut_sat (
    .clk     (clk),
    .rst     (rst),
    .pipe_io (bus2.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_err;
  logic [15:0] m_cnt;

  typedef struct {
    string       name;
    logic        mode;
    logic [31:0] din;
    logic [31:0] dout;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Index of lowest set bit via isolating it arithmetically.
  function automatic logic [31:0] ref_enc(input logic [31:0] x);
    logic [31:0] lsb;
    if (x == 32'd0) return 32'd0;
    lsb = x & (~x + 32'd1);
    return 32'($clog2(lsb));
  endfunction

  // One clock cycle: called at a falling edge, returns at the next one.
  task automatic cycle(input logic vi, input logic md, input logic [31:0] din, input logic ordy);
    logic exp_rdy, in_x, out_x;
    bus.in_valid  = vi;
    bus.in_mode   = md;
    bus.in_data   = din;
    bus.out_ready = ordy;
    #1;
    exp_rdy = !m_valid || ordy;
    check("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_rdy});
    in_x  = vi && exp_rdy;
    out_x = m_valid && ordy;
    if (out_x && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (in_x) begin
      m_valid = 1'b1;
      m_data  = md ? ref_enc(din) : (32'd1 << din[4:0]);
      m_err   = ERR_EN && md && (din == 32'd0);
    end else if (out_x) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("out_valid", {63'd0, bus.out_valid}, {63'd0, m_valid});
    check("out_data",  {32'd0, bus.out_data},  {32'd0, m_data});
    check("out_err",   {63'd0, bus.out_err},   {63'd0, m_err});
    check("txn_count", {48'd0, bus.txn_count}, {48'd0, m_cnt});
    @(negedge clk);
  endtask

  // Reset with a transfer offered on both sides; reset must win.
  task automatic do_reset(input logic vi, input logic ordy);
    rst           = 1'b1;
    bus.in_valid  = vi;
    bus.in_mode   = 1'b0;
    bus.in_data   = 32'd3;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    m_valid = 1'b0;
    m_data  = 32'd0;
    m_err   = 1'b0;
    m_cnt   = 16'd0;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_data",  {32'd0, bus.out_data},  64'd0);
    check("rst_out_err",   {63'd0, bus.out_err},   64'd0);
    check("rst_txn_count", {48'd0, bus.txn_count}, 64'd0);
    bus.in_valid = 1'b0;
    #1;
    check("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    vecs[0] = '{"dec_0",        1'b0, 32'd0,          32'h0000_0001, 1'b0};
    vecs[1] = '{"dec_7",        1'b0, 32'd7,          32'h0000_0080, 1'b0};
    vecs[2] = '{"dec_31",       1'b0, 32'd31,         32'h8000_0000, 1'b0};
    vecs[3] = '{"dec_upper_ign",1'b0, 32'hFFFF_FFE3,  32'h0000_0008, 1'b0};
    vecs[4] = '{"enc_a00",      1'b1, 32'h0000_0A00,  32'd9,         1'b0};
    vecs[5] = '{"enc_msb",      1'b1, 32'h8000_0000,  32'd31,        1'b0};
    vecs[6] = '{"enc_lsb",      1'b1, 32'h0000_0001,  32'd0,         1'b0};
    vecs[7] = '{"enc_zero",     1'b1, 32'h0000_0000,  32'd0,         ERR_EN};
    vecs[8] = '{"enc_all",      1'b1, 32'hFFFF_FFFF,  32'd0,         1'b0};
    vecs[9] = '{"enc_bit16",    1'b1, 32'h0001_0000,  32'd16,        1'b0};

    bus.in_valid   = 1'b0;
    bus.in_mode    = 1'b0;
    bus.in_data    = 32'd0;
    bus.out_ready  = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.in_mode   = 1'b0;
    bus2.in_data   = 32'd0;
    bus2.out_ready = 1'b0;
    @(negedge clk);
    do_reset(1'b1, 1'b1);

    // Directed vectors, back-to-back with mixed modes
    foreach (vecs[k]) begin
      cycle(1'b1, vecs[k].mode, vecs[k].din, 1'b1);
      check(vecs[k].name, {32'd0, bus.out_data}, {32'd0, vecs[k].dout});
      check({vecs[k].name, "_err"}, {63'd0, bus.out_err}, {63'd0, vecs[k].err});
    end
    cycle(1'b0, 1'b0, 32'd0, 1'b1);

    // Decode sweep: 32 back-to-back transfers then drain
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, 1'b0, 32'(i), 1'b1);
      check("sweep_valid", {63'd0, bus.out_valid}, 64'd1);
    end
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    check("sweep_count", {48'd0, bus.txn_count}, 64'd32);

    // Backpressure: hold decode 7 for five stalled cycles
    cycle(1'b1, 1'b0, 32'd7, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 32'h0000_0100 << i, 1'b0);
      check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check("bp_hold", {32'd0, bus.out_data}, 64'h80);
    end
    cycle(1'b1, 1'b0, 32'd3, 1'b1);
    check("bp_release", {32'd0, bus.out_data}, 64'h8);
    check("bp_count", {48'd0, bus.txn_count}, 64'd33);

    // Reset while FULL and stalled, with transfers offered during reset
    cycle(1'b1, 1'b0, 32'd5, 1'b0);
    do_reset(1'b1, 1'b1);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       rd = 32'd0;
        1:       rd = 32'd1 << $urandom_range(0, 31);
        2:       rd = $urandom;
        default: rd = $urandom & $urandom & $urandom;
      endcase
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), rd,
            1'($urandom_range(0, 2) != 0));
    end

    // Saturation on the 4-bit counter instance
    do_reset(1'b0, 1'b0);
    bus2.in_valid  = 1'b1;
    bus2.in_mode   = 1'b0;
    bus2.in_data   = 32'd1;
    bus2.out_ready = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      @(posedge clk);
      #1;
      check("sat_count", {60'd0, bus2.txn_count},
            64'((k - 1) > 15 ? 15 : (k - 1)));
    end
    bus2.in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/decenc_pipe.md
DECENC_PIPE -- requirements
Module: decenc_pipe

Interface
REQ-001 Parameter SEL_W, default 5: index width; legal range 1..8.
REQ-002 Parameter DATA_W, default 2**SEL_W: one-hot bus width; SHALL NOT be overridden independently of SEL_W.
REQ-003 Parameter CNT_W, default 16: transaction counter width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  input transfer request.
REQ-007 in_ready  output  1  block can accept input this cycle.
REQ-008 in_mode  input  1  0 = decode (index to one-hot), 1 = encode (bus to index).
REQ-009 in_data  input  DATA_W  decode: index in bits [SEL_W-1:0], upper bits ignored; encode: full bus.
REQ-010 out_valid  output  1  result held in output register.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 out_data  output  DATA_W  decode: one-hot; encode: index zero-extended to DATA_W.
REQ-013 out_err  output  1  encode of all-zero bus (see Configuration).
REQ-014 txn_count  output  CNT_W  count of completed output transfers.

Function
REQ-015 Input transfer SHALL occur when in_valid and in_ready are both high at a rising edge.
REQ-016 Output transfer SHALL occur when out_valid and out_ready are both high at a rising edge.
REQ-017 Two-state control: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-018 EMPTY -> FULL on input transfer; FULL -> EMPTY on output transfer with no input transfer; FULL -> FULL on simultaneous input and output transfer (register reloaded).
REQ-019 in_ready SHALL equal (!out_valid || out_ready), combinationally; no input transfer is lost or duplicated.
REQ-020 Latency: result SHALL appear on out_data with out_valid=1 in the cycle after the input transfer.
REQ-021 While FULL and out_ready=0, out_data, out_err and out_valid SHALL hold stable regardless of input activity.
REQ-022 Decode: out_data SHALL be exactly 1 << in_data[SEL_W-1:0]; every index 0..DATA_W-1 is legal.
REQ-023 Encode: out_data SHALL hold the index of the lowest set bit of in_data (LSB priority), upper bits zero.
REQ-024 Encode with in_data = 0: out_data SHALL be 0.
REQ-025 Mode is sampled per transfer; consecutive transfers may alternate mode with no bubble.
REQ-026 txn_count SHALL increment by 1 on each output transfer and saturate at 2**CNT_W-1 (no wrap).
REQ-027 out_data and out_err SHALL NOT change in cycles with no input transfer.

Reset
REQ-028 With rst high at a rising edge: out_valid=0, out_data=0, out_err=0, txn_count=0, state EMPTY.
REQ-029 Reset SHALL override simultaneous input/output transfers; an in-flight result is discarded and not counted.
REQ-030 in_ready SHALL be 1 in the cycle after reset (EMPTY state).

Configuration
REQ-031 Macro DECENC_ERR_EN defined: out_err SHALL register 1 with an encode transfer whose in_data is all-zero, and 0 with any other transfer.
REQ-032 Macro DECENC_ERR_EN undefined: out_err port SHALL remain present and tied to 0; no detection logic is synthesised.

Verification
REQ-033 Decode sweep, SEL_W=5, out_ready=1: in_data 0..31 back-to-back -> out_data = 1<<i one cycle later, out_valid continuously 1, txn_count = 32 at end.
REQ-034 Encode priority: in_data=0x0000_0A00 mode=1 -> out_data=9; in_data=0x8000_0000 -> 31; in_data=0x0000_0001 -> 0.
REQ-035 Backpressure: load decode 7, hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_data=0x80 stable; release -> next input accepted in the same cycle as the output transfer.
REQ-036 Zero encode: mode=1 in_data=0 -> out_data=0; out_err=1 with DECENC_ERR_EN defined, 0 without.
REQ-037 Reset mid-operation: FULL with out_ready=0, assert rst one cycle -> out_valid=0, txn_count=0, in_ready=1 next cycle.
REQ-038 Saturation, CNT_W=4: 20 output transfers -> txn_count reaches 15 and holds.
